mic_sample_ctrl: RTL and testbench
==================================

MIC_SAMPLE_CTRL -- requirements
Module: mic_sample_ctrl

Interface
REQ-001 Parameter CHANNELS, 2: number of ADCs sharing sclk and cs_b, each with its own MISO line.
REQ-002 Parameter DATA_W, 12: data bits kept per channel per frame.
REQ-003 Parameter FRAME_BITS, 16: sclk periods per frame; SHALL be >= DATA_W.
REQ-004 Parameter CLK_DIV, 8: sysclk cycles per sclk period; SHALL be even and >= 2; H = CLK_DIV/2.
REQ-005 Parameter FIFO_DEPTH, 4: sample FIFO entries; SHALL be a power of 2 and >= 2.
REQ-006 Parameter PERIOD, 200: sysclk cycles between frame starts in continuous mode; SHALL be > H*(2*FRAME_BITS+2).
REQ-007 sysclk  in  1  the only clock; all logic SHALL be on its rising edge.
REQ-008 reset  in  1  synchronous, active-high.
REQ-009 trigger  in  1  single-shot request; a rising edge starts one frame.
REQ-010 continuous  in  1  when 1, frames start every PERIOD cycles.
REQ-011 miso  in  CHANNELS  serial data, one bit per channel.
REQ-012 cs_b  out  1  shared chip select, active low.
REQ-013 sclk  out  1  shared serial clock, idle high.
REQ-014 rd_en  in  1  pops the FIFO head.
REQ-015 rd_data  out  CHANNELS*DATA_W  FIFO head, first-word-fall-through; channel k in bits [k*DATA_W +: DATA_W].
REQ-016 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-017 fifo_empty, fifo_full  out  1 each  count==0, count==FIFO_DEPTH.
REQ-018 overflow  out  1  sticky; a completed sample was dropped.
REQ-019 missed  out  1  sticky; a start request arrived while not IDLE.
REQ-020 clear_flags  in  1  clears overflow and missed.
REQ-021 interrupt  out  1  one-cycle pulse on each FIFO write.
REQ-022 busy  out  1  state != IDLE.

Function
REQ-023 The start request SHALL be (trigger & ~trigger_d) | period_tick; trigger_d is trigger registered one cycle earlier.
REQ-024 States SHALL be IDLE, SETUP, SHIFT, QUIET; on a start request in IDLE, the same edge SHALL drive cs_b low and enter SETUP.
REQ-025 SETUP SHALL last H cycles with cs_b=0 and sclk=1, then enter SHIFT.
REQ-026 SHIFT SHALL run FRAME_BITS sclk periods; each period is H cycles sclk=0 followed by H cycles sclk=1.
REQ-027 On the edge that drives sclk 0->1, each channel's miso SHALL shift into its shift register, MSB first.
REQ-028 After the last sclk-high half, the same edge SHALL set cs_b=1 and sclk=1 and attempt a FIFO write of the last DATA_W bits per channel, then enter QUIET.
REQ-029 QUIET SHALL last H cycles with cs_b=1, then return to IDLE; cs_b low time per frame SHALL be H + FRAME_BITS*CLK_DIV cycles.
REQ-030 A start request in any state other than IDLE SHALL be ignored and SHALL set missed.
REQ-031 The period counter SHALL count 0..PERIOD-1 while continuous=1, assert period_tick at PERIOD-1, and hold at 0 while continuous=0.
REQ-032 A write when full with rd_en=0 SHALL be dropped, set overflow, and leave FIFO contents unchanged.
REQ-033 A write and rd_en in the same cycle when full SHALL both succeed, leaving the count unchanged with no overflow.
REQ-034 rd_en when empty SHALL be ignored; count SHALL not underflow.
REQ-035 interrupt SHALL pulse only for writes that succeed.
REQ-036 If clear_flags and a flag-setting event occur in the same cycle, the set SHALL win.
REQ-037 Pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-038 On reset: cs_b=1, sclk=1, state=IDLE, FIFO empty (count 0), overflow=0, missed=0, interrupt=0, busy=0, period counter=0, trigger_d=0.
REQ-039 Reset mid-frame SHALL abort on the next edge with no FIFO write; the partial sample is discarded.
REQ-040 A trigger held high through reset release SHALL NOT start a frame.

Verification (CHANNELS=2, DATA_W=12, FRAME_BITS=16, CLK_DIV=8, FIFO_DEPTH=4)
REQ-041 One trigger pulse, ch0 serves 0x0ABC, ch1 serves 0x0123 -> cs_b low for exactly 132 cycles, 16 sclk pulses, interrupt pulses once, fifo_count=1, rd_data=0x123ABC.
REQ-042 trigger held high for 500 cycles -> exactly one frame, missed=0.
REQ-043 Five back-to-back frames with no reads -> fifo_count=4, overflow=1, the first four samples read back in order.
REQ-044 continuous=1 for 1000 cycles from reset -> 5 frames, cs_b falling edges 200 cycles apart.
REQ-045 reset asserted at sclk period 7 of SHIFT -> cs_b=1 and sclk=1 on the next edge, fifo_empty=1, no interrupt.
REQ-046 FIFO full, frame completes with rd_en=1 on the write cycle -> fifo_count stays 4, overflow=0, the new sample is at the tail.

Source files
------------

// File: rtl/mic_sample_ctrl.sv
// Frame sequencer for CHANNELS serial ADCs sharing sclk/cs_b, plus a first-word-fall-through
// sample FIFO. A frame starts on a rising trigger or on each continuous-mode period tick.
module mic_sample_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int DATA_W     = 12,
    parameter int FRAME_BITS = 16,
    parameter int CLK_DIV    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PERIOD     = 200
) (
    input  logic                         i_sysclk,
    input  logic                         i_reset,
    input  logic                         i_trigger,
    input  logic                         i_continuous,
    input  logic [CHANNELS-1:0]          i_miso,
    output logic                         o_cs_b,
    output logic                         o_sclk,
    input  logic                         i_rd_en,
    output logic [CHANNELS*DATA_W-1:0]   o_rd_data,
    output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count,
    output logic                         o_fifo_empty,
    output logic                         o_fifo_full,
    output logic                         o_overflow,
    output logic                         o_missed,
    input  logic                         i_clear_flags,
    output logic                         o_interrupt,
    output logic                         o_busy
);

    localparam int H  = CLK_DIV / 2;
    localparam int HW = (H > 1) ? $clog2(H) : 1;
    localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CHANNELS * DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_cs_b, r_sclk, w_cs_b_nxt, w_sclk_nxt;
    logic [HW-1:0]   r_half_cnt;
    logic [BW-1:0]   r_bit_cnt;
    logic [PW-1:0]   r_period_cnt;
    logic            r_trigger_d, r_trig_block;
    logic            r_overflow, r_missed, r_interrupt;
    logic [DATA_W-1:0] r_shift [CHANNELS];
    logic [SW-1:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic w_period_tick, w_start, w_half_last, w_bit_last;
    logic w_shift_en, w_bit_adv, w_frame_done;
    logic w_full, w_pop, w_push, w_drop;
    logic [SW-1:0] w_sample;

    assign w_period_tick = i_continuous & (r_period_cnt == PW'(PERIOD - 1));
    // A trigger already high when reset releases stays blocked until it has been seen low.
    assign w_start       = (i_trigger & ~r_trigger_d & ~r_trig_block) | w_period_tick;
    assign w_half_last   = (r_half_cnt == HW'(H - 1));
    assign w_bit_last    = (r_bit_cnt == BW'(FRAME_BITS - 1));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
        w_state_nxt  = r_state;
        w_cs_b_nxt   = r_cs_b;
        w_sclk_nxt   = r_sclk;
        w_shift_en   = 1'b0;
        w_bit_adv    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) begin
                w_state_nxt = S_SETUP;
                w_cs_b_nxt  = 1'b0;
            end
            S_SETUP: if (w_half_last) begin
                w_state_nxt = S_SHIFT;
                w_sclk_nxt  = 1'b0;
            end
            S_SHIFT: if (w_half_last) begin
                if (!r_sclk) begin
                    w_sclk_nxt = 1'b1;
                    w_shift_en = 1'b1;
                end else if (w_bit_last) begin
                    w_cs_b_nxt   = 1'b1;
                    w_frame_done = 1'b1;
                    w_state_nxt  = S_QUIET;
                end else begin
                    w_sclk_nxt = 1'b0;
                    w_bit_adv  = 1'b1;
                end
            end
            S_QUIET: if (w_half_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sysclk) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values regardless of block order.
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_cs_b     <= 1'b1;
            r_sclk     <= 1'b1;
            r_half_cnt <= '0;
            r_bit_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cs_b     <= w_cs_b_nxt;
            r_sclk     <= w_sclk_nxt;
            r_half_cnt <= (r_state == S_IDLE || w_half_last) ? '0 : r_half_cnt + HW'(1);
            if (r_state != S_SHIFT) r_bit_cnt <= '0;
            else if (w_bit_adv)     r_bit_cnt <= r_bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_period_cnt <= '0;
            r_trigger_d  <= 1'b0;
            r_trig_block <= i_trigger;
        end else begin
            r_period_cnt <= (!i_continuous || w_period_tick) ? '0 : r_period_cnt + PW'(1);
            r_trigger_d  <= i_trigger;
            r_trig_block <= r_trig_block & i_trigger;
        end
    end

    always_ff @(posedge i_sysclk) begin
        if (w_shift_en) begin
            for (int k = 0; k < CHANNELS; k++)
                r_shift[k] <= {r_shift[k][DATA_W-2:0], i_miso[k]};
        end
    end

    always_comb begin
        w_sample = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_sample[k*DATA_W +: DATA_W] = r_shift[k];
    end

    // A full FIFO still accepts a sample when the head is popped on the same edge.
    assign w_full = (r_count == CW'(FIFO_DEPTH));
    assign w_pop  = i_rd_en & (r_count != '0);
    assign w_push = w_frame_done & (~w_full | w_pop);
    assign w_drop = w_frame_done & w_full & ~w_pop;

    // NOTE: the sample array is left out of reset; pointers and count alone define which entries are valid.
    always_ff @(posedge i_sysclk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_sample;
    end

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_missed    <= 1'b0;
            r_interrupt <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            r_overflow  <= w_drop | (r_overflow & ~i_clear_flags);
            r_missed    <= (w_start & (r_state != S_IDLE)) | (r_missed & ~i_clear_flags);
            r_interrupt <= w_push;
        end
    end

    assign o_cs_b       = r_cs_b;
    assign o_sclk       = r_sclk;
    assign o_rd_data    = r_mem[r_rd_ptr];
    assign o_fifo_count = r_count;
    assign o_fifo_empty = (r_count == '0);
    assign o_fifo_full  = w_full;
    assign o_overflow   = r_overflow;
    assign o_missed     = r_missed;
    assign o_interrupt  = r_interrupt;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mic_sample_ctrl.sv
// Bench for mic_sample_ctrl: a frame-timeline reference model drives the ADC lines and predicts
// every output each cycle; directed scenarios cover the single-shot, continuous and FIFO corners.
module tb_mic_sample_ctrl;

    localparam int CHANNELS   = 2;
    localparam int DATA_W     = 12;
    localparam int FRAME_BITS = 16;
    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int PERIOD     = 200;
    localparam int H          = CLK_DIV / 2;
    localparam int SHIFT_END  = H + FRAME_BITS * CLK_DIV;
    localparam int FRAME_LEN  = SHIFT_END + H;
    localparam int SW         = CHANNELS * DATA_W;
    localparam int CW         = $clog2(FIFO_DEPTH) + 1;

    logic sysclk = 1'b0;
    logic reset, trigger, continuous, rd_en, clear_flags;
    logic [CHANNELS-1:0] miso;
    logic cs_b, sclk, fifo_empty, fifo_full, overflow, missed, interrupt, busy;
    logic [SW-1:0] rd_data;
    logic [CW-1:0] fifo_count;

    always #5 sysclk = ~sysclk;

    mic_sample_ctrl #(
        .CHANNELS(CHANNELS), .DATA_W(DATA_W), .FRAME_BITS(FRAME_BITS),
        .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .PERIOD(PERIOD)
    ) dut (
        .i_sysclk(sysclk), .i_reset(reset), .i_trigger(trigger), .i_continuous(continuous),
        .i_miso(miso), .o_cs_b(cs_b), .o_sclk(sclk), .i_rd_en(rd_en), .o_rd_data(rd_data),
        .o_fifo_count(fifo_count), .o_fifo_empty(fifo_empty), .o_fifo_full(fifo_full),
        .o_overflow(overflow), .o_missed(missed), .i_clear_flags(clear_flags),
        .o_interrupt(interrupt), .o_busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc_n);
        end
    endtask

    // Reference model: m_t counts cycles since the frame-start edge, -1 when idle.
    int  m_t = -1;
    int  m_pcnt = 0;
    bit  m_trig_prev = 1'b0, m_armed = 1'b0;
    bit  m_ov = 1'b0, m_missed = 1'b0, m_irq = 1'b0;
    bit  use_fixed = 1'b0;
    logic [FRAME_BITS-1:0] m_word [CHANNELS];
    logic [FRAME_BITS-1:0] fixed_word [CHANNELS];
    logic [SW-1:0] m_fifo [$];

    int obs_cs_low, obs_sclk_rise, obs_irq, obs_falls;
    logic prev_cs_b = 1'b1, prev_sclk = 1'b1;
    int fall_at [$];

    task automatic model_edge();
        logic [SW-1:0] d;
        bit tick, rise, start, wr, pop, ok;
        if (reset) begin
            m_t = -1; m_pcnt = 0; m_fifo.delete();
            m_ov = 1'b0; m_missed = 1'b0; m_irq = 1'b0;
            m_trig_prev = 1'b0; m_armed = !trigger;
        end else begin
            tick  = continuous && (m_pcnt == PERIOD - 1);
            rise  = trigger && !m_trig_prev && m_armed;
            start = rise || tick;
            m_pcnt = (continuous && m_pcnt != PERIOD - 1) ? m_pcnt + 1 : 0;
            m_trig_prev = trigger;
            if (!trigger) m_armed = 1'b1;
            for (int k = 0; k < CHANNELS; k++) d[k*DATA_W +: DATA_W] = m_word[k][DATA_W-1:0];
            wr  = (m_t == SHIFT_END - 1);
            pop = rd_en && (m_fifo.size() > 0);
            ok  = wr && (m_fifo.size() < FIFO_DEPTH || pop);
            if (pop) void'(m_fifo.pop_front());
            if (ok)  m_fifo.push_back(d);
            m_irq    = ok;
            m_ov     = (wr && !ok) || (m_ov && !clear_flags);
            m_missed = (start && m_t >= 0) || (m_missed && !clear_flags);
            if (m_t >= 0) begin
                m_t++;
                if (m_t == FRAME_LEN) m_t = -1;
            end else if (start) begin
                m_t = 0;
                for (int k = 0; k < CHANNELS; k++)
                    m_word[k] = use_fixed ? fixed_word[k] : FRAME_BITS'($urandom);
            end
        end
    endtask

    task automatic drive_miso();
        for (int k = 0; k < CHANNELS; k++) begin
            if (m_t >= H && m_t < SHIFT_END)
                miso[k] = m_word[k][FRAME_BITS - 1 - ((m_t - H) / CLK_DIV)];
            else
                miso[k] = 1'($urandom);
        end
    endtask

    task automatic compare_all();
        bit exp_cs_b, exp_sclk;
        exp_cs_b = !(m_t >= 0 && m_t < SHIFT_END);
        exp_sclk = !(m_t >= H && m_t < SHIFT_END && ((m_t - H) % CLK_DIV) < H);
        cyc_n++;
        check("cs_b", cs_b, exp_cs_b);
        check("sclk", sclk, exp_sclk);
        check("busy", busy, m_t >= 0);
        check("interrupt", interrupt, m_irq);
        check("overflow", overflow, m_ov);
        check("missed", missed, m_missed);
        check("fifo_count", fifo_count, m_fifo.size());
        check("fifo_empty", fifo_empty, m_fifo.size() == 0);
        check("fifo_full", fifo_full, m_fifo.size() == FIFO_DEPTH);
        if (m_fifo.size() > 0) check("rd_data", rd_data, m_fifo[0]);
        if (cs_b === 1'b0) obs_cs_low++;
        if (prev_sclk === 1'b0 && sclk === 1'b1) obs_sclk_rise++;
        if (interrupt === 1'b1) obs_irq++;
        if (prev_cs_b === 1'b1 && cs_b === 1'b0) begin
            obs_falls++;
            fall_at.push_back(cyc_n);
        end
        prev_cs_b = cs_b;
        prev_sclk = sclk;
    endtask

    task automatic cyc();
        drive_miso();
        @(posedge sysclk);
        model_edge();
        @(negedge sysclk);
        compare_all();
    endtask

    task automatic clear_obs();
        obs_cs_low = 0; obs_sclk_rise = 0; obs_irq = 0; obs_falls = 0;
        fall_at.delete();
    endtask

    task automatic run_to_write_cycle();
        int g = 0;
        while (m_t != SHIFT_END - 1 && g < 400) begin
            cyc();
            g++;
        end
        check("reach_write_cycle", m_t, SHIFT_END - 1);
    endtask

    initial begin
        reset = 1'b1; trigger = 1'b1; continuous = 1'b0; rd_en = 1'b0; clear_flags = 1'b0; miso = '0;
        fixed_word[0] = 16'h0ABC;
        fixed_word[1] = 16'h0123;
        for (int k = 0; k < CHANNELS; k++) m_word[k] = '0;
        clear_obs();

        // Trigger held high across reset release must not start a frame.
        repeat (4) cyc();
        reset = 1'b0;
        repeat (50) cyc();
        check("held_trigger_no_frame", obs_falls, 0);
        trigger = 1'b0;
        repeat (3) cyc();

        // Single frame with known ADC words.
        use_fixed = 1'b1;
        clear_obs();
        trigger = 1'b1; cyc(); trigger = 1'b0;
        repeat (160) cyc();
        use_fixed = 1'b0;
        check("single_cs_low_cycles", obs_cs_low, 132);
        check("single_sclk_pulses", obs_sclk_rise, 16);
        check("single_irq_count", obs_irq, 1);
        check("single_fifo_count", fifo_count, 1);
        check("single_rd_data", rd_data, 24'h123ABC);
        rd_en = 1'b1; cyc(); rd_en = 1'b0; cyc();

        // Trigger held for 500 cycles gives exactly one frame.
        clear_obs();
        trigger = 1'b1; repeat (500) cyc(); trigger = 1'b0;
        repeat (20) cyc();
        check("held_frames", obs_falls, 1);
        check("held_irq_count", obs_irq, 1);
        check("held_missed", missed, 0);
        rd_en = 1'b1; repeat (2) cyc(); rd_en = 1'b0;

        // Five frames without reads: the fifth sample is dropped.
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            trigger = 1'b1; cyc(); trigger = 1'b0;
            repeat (FRAME_LEN + 2) cyc();
        end
        check("five_fifo_count", fifo_count, 4);
        check("five_overflow", overflow, 1);
        check("five_irq_count", obs_irq, 4);
        rd_en = 1'b1; repeat (4) cyc(); rd_en = 1'b0; cyc();
        check("five_drained", fifo_empty, 1);

        // Full FIFO, read on the write edge: count stays at depth, no overflow.
        clear_flags = 1'b1; cyc(); clear_flags = 1'b0;
        clear_obs();
        for (int i = 0; i < 5; i++) begin
            trigger = 1'b1; cyc(); trigger = 1'b0;
            run_to_write_cycle();
            if (i == 4) rd_en = 1'b1;
            cyc();
            rd_en = 1'b0;
            repeat (H + 2) cyc();
        end
        check("full_rw_count", fifo_count, 4);
        check("full_rw_overflow", overflow, 0);
        check("full_rw_irq_count", obs_irq, 5);
        rd_en = 1'b1; repeat (4) cyc(); rd_en = 1'b0; cyc();

        // Reset in the middle of sclk period 7 aborts the frame without a write.
        clear_obs();
        trigger = 1'b1; cyc(); trigger = 1'b0;
        begin
            int g = 0;
            while (m_t < H + 7 * CLK_DIV + 1 && g < 400) begin cyc(); g++; end
        end
        check("mid_in_shift", busy, 1);
        reset = 1'b1; cyc(); reset = 1'b0;
        check("mid_cs_b", cs_b, 1);
        check("mid_sclk", sclk, 1);
        check("mid_fifo_empty", fifo_empty, 1);
        check("mid_interrupt", interrupt, 0);
        repeat (150) cyc();
        check("mid_irq_count", obs_irq, 0);

        // Continuous mode for 1000 cycles straight out of reset.
        reset = 1'b1; repeat (2) cyc();
        reset = 1'b0; continuous = 1'b1; rd_en = 1'b1;
        clear_obs();
        repeat (1000) cyc();
        continuous = 1'b0;
        repeat (200) cyc();
        rd_en = 1'b0;
        check("cont_frames", obs_falls, 5);
        check("cont_irq_count", obs_irq, 5);
        for (int i = 1; i < fall_at.size(); i++)
            check("cont_gap", fall_at[i] - fall_at[i-1], PERIOD);

        // Randomized traffic: triggers, continuous bursts, reads, flag clears and stray resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 5)   trigger = ~trigger;
            if ($urandom_range(0, 399) == 0) continuous = ~continuous;
            rd_en       = ($urandom_range(0, 2) == 0);
            clear_flags = ($urandom_range(0, 49) == 0);
            reset       = ($urandom_range(0, 1499) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
